// File: rtl/video_to_axis.sv
// -----------------------------------------------------------------------------
// video_to_axis
//
// Converts a parallel video stream (hsync/vsync/active_video/data), sampled in
// the pixel clock domain, into an AXI4-Stream video master. Pixels pass through
// a first-word-fall-through FIFO of 2**ADDR_BITS entries so that downstream
// backpressure can be absorbed. Every beat carries tuser on frame pixel (0,0)
// and tlast on the last pixel of a line (x == H_DISP-1).
//
// Frame geometry is checked against H_DISP x V_DISP. locked reports that the
// last complete frame had exactly V_DISP lines of exactly H_DISP pixels.
//
// Capture state machine:
//   WAIT_VS : pixels discarded until a vsync assert edge.
//   CAPTURE : in-window pixels are written to the FIFO.
//   DROP    : entered on a FIFO overflow; pixels are discarded (each one
//             pulses overflow) until the next vsync assert edge.
//
// Optional feature (compile-time macro VIDEO_TO_AXIS_MEASURE_EN):
//   meas_width  : pixel count of the last completed line, sampled at vsync
//   meas_height : line count of the previous frame, sampled at vsync
//
// Ports:
//   aclk              in   1          clock (video and AXIS)
//   areset            in   1          synchronous reset, active-high
//   vid_hsync         in   1          horizontal sync, polarity H_POL
//   vid_vsync         in   1          vertical sync, polarity V_POL
//   vid_active_video  in   1          pixel valid
//   vid_data          in   DATA_BITS  pixel
//   m_axis_tdata      out  DATA_BITS  pixel
//   m_axis_tvalid     out  1          FIFO not empty
//   m_axis_tready     in   1          downstream accept
//   m_axis_tlast      out  1          last pixel of line
//   m_axis_tuser      out  1          first pixel of frame
//   locked            out  1          last complete frame had the expected geometry
//   overflow          out  1          one-cycle pulse per dropped pixel
//   meas_width        out  16         (VIDEO_TO_AXIS_MEASURE_EN only)
//   meas_height       out  16         (VIDEO_TO_AXIS_MEASURE_EN only)
// -----------------------------------------------------------------------------
module video_to_axis #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 6,
    parameter int H_DISP    = 640,
    parameter int V_DISP    = 480,
    parameter bit H_POL     = 1'b0,
    parameter bit V_POL     = 1'b1
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 vid_hsync,
    input  logic                 vid_vsync,
    input  logic                 vid_active_video,
    input  logic [DATA_BITS-1:0] vid_data,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic                 locked,
    output logic                 overflow
`ifdef VIDEO_TO_AXIS_MEASURE_EN
    ,
    output logic [15:0]          meas_width,
    output logic [15:0]          meas_height
`endif
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int CW    = 16;                 // x/y counter width
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int W     = DATA_BITS + 2;      // {tuser, tlast, data}

    localparam logic [CW-1:0]      H_END   = CW'(H_DISP);
    localparam logic [CW-1:0]      H_LAST  = CW'(H_DISP - 1);
    localparam logic [CW-1:0]      V_END   = CW'(V_DISP);
    localparam logic [CW-1:0]      CNT_ONE = CW'(1);
    localparam logic [ADDR_BITS:0] PTR_ONE = (ADDR_BITS + 1)'(1);

    localparam logic [1:0] ST_WAIT_VS = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DROP    = 2'd2;

    // -------------------------------------------------------------------------
    // Input stage: one register on every video input. Syncs are stored
    // polarity-normalised (1 = asserted) so edge detection is polarity-free.
    // -------------------------------------------------------------------------
    logic                 hs_r, vs_r, act_r;
    logic                 hs_d, vs_d, act_d;
    logic [DATA_BITS-1:0] data_r;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the clock edge, independent of block order.
    always_ff @(posedge aclk) begin
        if (areset) begin
            hs_r  <= 1'b0;
            vs_r  <= 1'b0;
            act_r <= 1'b0;
            hs_d  <= 1'b0;
            vs_d  <= 1'b0;
            act_d <= 1'b0;
        end else begin
            hs_r  <= vid_hsync ~^ H_POL;
            vs_r  <= vid_vsync ~^ V_POL;
            act_r <= vid_active_video;
            hs_d  <= hs_r;
            vs_d  <= vs_r;
            act_d <= act_r;
        end
    end

    // Pixel data is qualified by act_r, so it needs no reset.
    always_ff @(posedge aclk) begin
        data_r <= vid_data;
    end

    logic vs_edge;    // vsync assert edge
    logic hs_edge;    // hsync assert edge
    logic act_fall;   // end of an active run

    assign vs_edge  = vs_r & ~vs_d;
    assign hs_edge  = hs_r & ~hs_d;
    assign act_fall = ~act_r & act_d;

    // -------------------------------------------------------------------------
    // FIFO pointers and status. The extra MSB separates full from empty.
    // -------------------------------------------------------------------------
    logic [ADDR_BITS:0] wr_ptr, rd_ptr;
    logic               fifo_empty, fifo_full;
    logic               rd_en, wr_en, can_write;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                        (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);
    assign rd_en      = !fifo_empty && m_axis_tready;
    // A read in the same cycle frees a slot, so a write to a full FIFO still
    // succeeds when the head is being consumed.
    assign can_write  = !fifo_full || rd_en;

    // -------------------------------------------------------------------------
    // Capture control
    // -------------------------------------------------------------------------
    logic [1:0]    state;
    logic [CW-1:0] x, y;
    logic          frame_good;

    logic [1:0]    state_eff;
    logic [CW-1:0] y_eff;
    logic [CW-1:0] frame_lines;
    logic          in_window;
    logic          pix_cap;
    logic          drop_full, drop_geom, drop_state;
    logic          run_fail;
    logic [W-1:0]  wr_word;

    // A vsync edge coinciding with an active pixel is handled first: the pixel
    // is seen in CAPTURE with y = 0, making it frame pixel (0,0).
    // NOTE: every signal below gets a value on every path, so no latch is inferred.
    always_comb begin
        state_eff   = vs_edge ? ST_CAPTURE : state;
        y_eff       = vs_edge ? '0 : y;
        in_window   = (x < H_END) && (y_eff < V_END);
        pix_cap     = act_r && (state_eff == ST_CAPTURE);
        wr_en       = pix_cap && in_window && can_write;
        drop_full   = pix_cap && in_window && !can_write;
        drop_geom   = pix_cap && !in_window;
        drop_state  = act_r && (state_eff == ST_DROP);
        run_fail    = act_fall && (state == ST_CAPTURE) && (x != H_END);
        // Line count including a run that ends in this very cycle.
        frame_lines = act_fall ? (y + CNT_ONE) : y;
        wr_word     = {((x == '0) && (y_eff == '0)), (x == H_LAST), data_r};
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= ST_WAIT_VS;
            x          <= '0;
            y          <= '0;
            frame_good <= 1'b0;
            locked     <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            overflow <= drop_full || drop_state;

            // x: active pixels seen in the current run (saturating). An hsync
            // edge in blanking also marks a fresh line.
            if (act_fall || (hs_edge && !act_r)) begin
                x <= '0;
            end else if (act_r && (x != '1)) begin
                x <= x + CNT_ONE;
            end

            // y: completed runs since the last vsync (saturating).
            if (vs_edge) begin
                y <= '0;
            end else if (act_fall && (y != '1)) begin
                y <= y + CNT_ONE;
            end

            // A short line loses lock; the partial line is left unterminated.
            if (run_fail) begin
                state  <= ST_WAIT_VS;
                locked <= 1'b0;
            end

            // Frame boundary: judge the frame just finished, start the next.
            if (vs_edge) begin
                state      <= ST_CAPTURE;
                frame_good <= 1'b1;
                if ((state == ST_CAPTURE) && !run_fail) begin
                    locked <= (frame_lines == V_END) && frame_good;
                end
            end

            // Pixel-level events come after the frame boundary so that a pixel
            // sharing the vsync cycle acts on the new frame.
            if (drop_geom) begin
                frame_good <= 1'b0;
            end
            if (drop_full) begin
                state  <= ST_DROP;
                locked <= 1'b0;
            end
            if (drop_state) begin
                locked <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage and pointers
    // -------------------------------------------------------------------------
    logic [W-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and the read side is masked while empty.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_BITS-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // AXIS output: first-word-fall-through. The head entry cannot be
    // overwritten while it is still valid, so the payload holds steady
    // under backpressure.
    // -------------------------------------------------------------------------
    logic [W-1:0] rd_word;

    assign rd_word       = mem[rd_ptr[ADDR_BITS-1:0]];
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0   : rd_word[DATA_BITS-1:0];
    assign m_axis_tlast  = fifo_empty ? 1'b0 : rd_word[W-2];
    assign m_axis_tuser  = fifo_empty ? 1'b0 : rd_word[W-1];

`ifdef VIDEO_TO_AXIS_MEASURE_EN
    // -------------------------------------------------------------------------
    // Geometry measurement, published at each vsync assert edge.
    // -------------------------------------------------------------------------
    logic [CW-1:0] last_width;

    always_ff @(posedge aclk) begin
        if (areset) begin
            last_width  <= '0;
            meas_width  <= '0;
            meas_height <= '0;
        end else begin
            if (act_fall) begin
                last_width <= x;
            end
            if (vs_edge) begin
                meas_width  <= act_fall ? x : last_width;
                meas_height <= frame_lines;
            end
        end
    end
`endif

endmodule

// File: tb/tb_video_to_axis.sv
// -----------------------------------------------------------------------------
// tb_video_to_axis
//
// Directed bench for video_to_axis (H_DISP=40, V_DISP=30, ADDR_BITS=6,
// H_POL=0, V_POL=1). A behavioural model built from the frame/line rules and
// a queue-based FIFO predicts tvalid, the head beat, overflow and locked on
// every cycle; literal expectations per scenario pin the model itself.
// -----------------------------------------------------------------------------
module tb_video_to_axis;

    localparam int H     = 40;
    localparam int V     = 30;
    localparam int AB    = 6;
    localparam int DEPTH = 1 << AB;
    localparam int DB    = 8;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          vid_hsync = 1'b1;
    logic          vid_vsync = 1'b0;
    logic          vid_active_video = 1'b0;
    logic [DB-1:0] vid_data = '0;
    logic          m_axis_tready = 1'b1;
    logic [DB-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          locked;
    logic          overflow;

    video_to_axis #(
        .DATA_BITS (DB),
        .ADDR_BITS (AB),
        .H_DISP    (H),
        .V_DISP    (V),
        .H_POL     (1'b0),
        .V_POL     (1'b1)
    ) dut (
        .aclk             (aclk),
        .areset           (areset),
        .vid_hsync        (vid_hsync),
        .vid_vsync        (vid_vsync),
        .vid_active_video (vid_active_video),
        .vid_data         (vid_data),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser     (m_axis_tuser),
        .locked           (locked),
        .overflow         (overflow)
    );

    always #5 aclk = ~aclk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model. The DUT sees each input one cycle later (input
    // register); "pend" holds that delayed view, "prev" the one before it.
    // -------------------------------------------------------------------------
    typedef enum {M_WAIT, M_CAPTURE, M_DROP} mode_t;

    mode_t      mode      = M_WAIT;
    logic [9:0] q[$];                 // expected FIFO contents {tuser, tlast, data}
    int         mx        = 0;
    int         my        = 0;
    bit         frame_ok  = 1'b0;
    bit         m_locked  = 1'b0;
    bit         m_ovf     = 1'b0;
    bit         pend_vs   = 1'b0;
    bit         pend_act  = 1'b0;
    bit         prev_vs   = 1'b0;
    bit         prev_act  = 1'b0;
    logic [7:0] pend_data = '0;

    initial begin
        forever begin
            @(posedge aclk);
            if (areset) begin
                q.delete();
                mode = M_WAIT;
                mx = 0; my = 0;
                frame_ok = 1'b0; m_locked = 1'b0; m_ovf = 1'b0;
                pend_vs = 1'b0; pend_act = 1'b0; prev_vs = 1'b0; prev_act = 1'b0;
            end else begin
                bit vs_edge, run_end;
                vs_edge = pend_vs && !prev_vs;
                run_end = prev_act && !pend_act;
                m_ovf   = 1'b0;

                // Downstream consumes the head first, freeing a slot.
                if ((q.size() != 0) && m_axis_tready) q.delete(0);

                if (run_end) begin
                    if (mode == M_CAPTURE && mx != H) begin
                        mode = M_WAIT;
                        m_locked = 1'b0;
                    end
                    mx = 0;
                    my++;
                end
                if (vs_edge) begin
                    if (mode == M_CAPTURE) m_locked = (my == V) && frame_ok;
                    mode = M_CAPTURE;
                    frame_ok = 1'b1;
                    my = 0;
                end
                if (pend_act) begin
                    case (mode)
                        M_CAPTURE: begin
                            if (mx >= H || my >= V) frame_ok = 1'b0;
                            else if (q.size() >= DEPTH) begin
                                m_ovf = 1'b1; m_locked = 1'b0; mode = M_DROP;
                            end else q.push_back({(mx == 0 && my == 0), (mx == H - 1), pend_data});
                        end
                        M_DROP: begin
                            m_ovf = 1'b1; m_locked = 1'b0;
                        end
                        default: ;
                    endcase
                    mx++;
                end
                prev_vs   = pend_vs;
                prev_act  = pend_act;
                pend_vs   = vid_vsync;   // V_POL = 1: high means asserted
                pend_act  = vid_active_video;
                pend_data = vid_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-cycle comparison against the model, on the falling edge.
    // -------------------------------------------------------------------------
    bit cmp_en = 1'b0;

    initial begin
        forever begin
            @(negedge aclk);
            if (cmp_en) begin
                check("tvalid", 32'(m_axis_tvalid), 32'(q.size() != 0));
                if (q.size() != 0)
                    check("beat{tuser,tlast,tdata}", 32'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 32'(q[0]));
                check("overflow", 32'(overflow), 32'(m_ovf));
                check("locked", 32'(locked), 32'(m_locked));
            end
        end
    end

    // Beat monitor feeding the literal scenario checks.
    int         beats = 0, tusers = 0, tlasts = 0, ovf_cnt = 0;
    logic [7:0] first_data = '0;
    bit         first_user = 1'b0;

    initial begin
        forever begin
            @(negedge aclk);
            if (m_axis_tvalid && m_axis_tready) begin
                if (beats == 0) begin
                    first_data = m_axis_tdata;
                    first_user = m_axis_tuser;
                end
                beats++;
                if (m_axis_tuser) tusers++;
                if (m_axis_tlast) tlasts++;
            end
            if (overflow) ovf_cnt++;
        end
    end

    task automatic clear_counts();
        beats = 0; tusers = 0; tlasts = 0; ovf_cnt = 0;
        first_data = 8'hff; first_user = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Video timing generator. Inputs change 1 time unit after the rising edge.
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        vid_active_video = 1'b0;
        repeat (n) tick();
    endtask

    task automatic vsync_pulse();
        vid_vsync = 1'b1;
        repeat (2) tick();
        vid_vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic line_start();
        vid_hsync = 1'b0;
        repeat (2) tick();
        vid_hsync = 1'b1;
        repeat (2) tick();
    endtask

    task automatic send_line(input int y, input int len);
        line_start();
        for (int x = 0; x < len; x++) begin
            vid_active_video = 1'b1;
            vid_data = 8'(y * H + x);
            tick();
        end
        vid_active_video = 1'b0;
        vid_data = '0;
        repeat (4) tick();
    endtask

    task automatic send_frame();
        vsync_pulse();
        for (int y = 0; y < V; y++) send_line(y, H);
    endtask

    task automatic check_full_frame(input string tag);
        check({tag, " beats"}, 32'(beats), 32'd1200);
        check({tag, " tuser count"}, 32'(tusers), 32'd1);
        check({tag, " tlast count"}, 32'(tlasts), 32'd30);
        check({tag, " first data"}, 32'(first_data), 32'd0);
        check({tag, " first tuser"}, 32'(first_user), 32'd1);
        check({tag, " overflow count"}, 32'(ovf_cnt), 32'd0);
    endtask

    // -------------------------------------------------------------------------
    // Directed scenarios
    // -------------------------------------------------------------------------
    initial begin
        // Reset state
        areset = 1'b1;
        repeat (3) tick();
        check("reset tvalid", 32'(m_axis_tvalid), 32'd0);
        check("reset tdata", 32'(m_axis_tdata), 32'd0);
        check("reset tlast/tuser", 32'({m_axis_tlast, m_axis_tuser}), 32'd0);
        check("reset locked", 32'(locked), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        areset = 1'b0;
        cmp_en = 1'b1;

        // Pixels before the first vsync are discarded
        clear_counts();
        send_line(0, H);
        send_line(1, H);
        idle(5);
        check("pre-vsync beats", 32'(beats), 32'd0);

        // Three clean frames with tready held high
        for (int f = 0; f < 3; f++) begin
            clear_counts();
            send_frame();
            idle(10);
            check_full_frame($sformatf("frame%0d", f));
            check($sformatf("frame%0d locked", f), 32'(locked), (f == 0) ? 32'd0 : 32'd1);
        end

        // tready low for one whole line: 40 entries fit, no overflow
        vsync_pulse();
        check("stall1 locked at vsync", 32'(locked), 32'd1);
        clear_counts();
        m_axis_tready = 1'b0;
        send_line(0, H);
        idle(4);
        check("stall1 overflow count", 32'(ovf_cnt), 32'd0);
        check("stall1 tvalid held", 32'(m_axis_tvalid), 32'd1);
        m_axis_tready = 1'b1;
        idle(50);
        check("stall1 drained beats", 32'(beats), 32'd40);
        check("stall1 drained tlast", 32'(tlasts), 32'd1);
        for (int y = 1; y < V; y++) send_line(y, H);
        idle(10);
        check("stall1 frame beats", 32'(beats), 32'd1200);

        // tready low for two lines: 64 stored, 16 dropped, DROP until vsync
        vsync_pulse();
        check("stall2 locked at vsync", 32'(locked), 32'd1);
        clear_counts();
        m_axis_tready = 1'b0;
        send_line(0, H);
        send_line(1, H);
        idle(5);
        check("stall2 overflow count", 32'(ovf_cnt), 32'd16);
        check("stall2 locked", 32'(locked), 32'd0);
        check("stall2 beats while stalled", 32'(beats), 32'd0);
        m_axis_tready = 1'b1;
        idle(80);
        check("stall2 drained beats", 32'(beats), 32'd64);
        check("stall2 drained tlast", 32'(tlasts), 32'd1);
        clear_counts();
        send_frame();
        idle(10);
        check_full_frame("post-drop");
        check("post-drop locked", 32'(locked), 32'd0);

        // Short line (39 pixels): lock lost, remaining lines ignored
        vsync_pulse();
        check("short locked at vsync", 32'(locked), 32'd1);
        clear_counts();
        send_line(0, H);
        send_line(1, H - 1);
        idle(3);
        check("short locked", 32'(locked), 32'd0);
        send_line(2, H);
        idle(10);
        check("short beats", 32'(beats), 32'd79);
        check("short tlast", 32'(tlasts), 32'd1);
        clear_counts();
        send_frame();
        idle(10);
        check_full_frame("after-short");
        vsync_pulse();
        check("after-short relock", 32'(locked), 32'd1);

        // Reset in the middle of a line with 10 entries queued
        clear_counts();
        m_axis_tready = 1'b0;
        line_start();
        for (int x = 0; x < 11; x++) begin
            vid_active_video = 1'b1;
            vid_data = 8'(x);
            tick();
        end
        check("pre-reset tvalid", 32'(m_axis_tvalid), 32'd1);
        check("pre-reset locked", 32'(locked), 32'd1);
        vid_data = 8'd11;
        areset = 1'b1;
        tick();
        check("post-reset tvalid", 32'(m_axis_tvalid), 32'd0);
        check("post-reset locked", 32'(locked), 32'd0);
        areset = 1'b0;
        m_axis_tready = 1'b1;
        idle(5);
        check("post-reset beats", 32'(beats), 32'd0);
        clear_counts();
        send_frame();
        idle(10);
        check_full_frame("after-reset");
        vsync_pulse();
        check("after-reset relock", 32'(locked), 32'd1);

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
